dmem_bridge: RTL and testbench
==============================

DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 10, which sets RAM depth to 2^DEPTH_LOG2 32-bit words.
REQ-002 SHALL have parameter CMP_RESET, default 32'hFFFF_FFFF, which is the reset value of TIMER_CMP.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port dce, input, 1 bit: data access enable from the core memory stage.
REQ-006 SHALL have port daddr, input, 32 bits: byte address.
REQ-007 SHALL have port we, input, 4 bits: byte-lane write enables; we[i] covers din[8i+7:8i].
REQ-008 SHALL have port din, input, 32 bits: write data, already lane-aligned.
REQ-009 SHALL have port dm, output, 32 bits: registered read data, consumed by the core write-back stage.
REQ-010 SHALL have port int_o, output, 6 bits: hardware interrupt lines to the core `int` input.
REQ-011 SHALL have port led, output, 16 bits: LED register contents.

Function
REQ-012 SHALL decode the access as MMIO when daddr[31:28]==4'hA; otherwise it is a RAM access at word index daddr[DEPTH_LOG2+1:2], with upper bits ignored (aliasing).
REQ-013 SHALL treat an access as a read when dce=1 and we=4'b0000, and as a write when dce=1 and we!=0.
REQ-014 SHALL, on a read, load dm at the next rising edge with the addressed word; read latency is exactly 1 cycle.
REQ-015 SHALL hold dm at its previous value in any cycle with no read, whether dce=0 or a write.
REQ-016 SHALL, on a RAM write, update only the bytes whose we bit is set; the other bytes keep their value.
REQ-017 SHALL define the MMIO map (offset daddr[3:2]) as: 0 LED (RW, bits[15:0]); 1 TIMER_CNT (RO); 2 TIMER_CMP (RW); 3 TIMER_CTRL with bit0 EN, bit1 PEND, bit2 AUTO.
REQ-018 SHALL apply MMIO writes only when we==4'b1111; partial-lane MMIO writes SHALL be ignored.
REQ-019 SHALL return 0 for MMIO reads with daddr[27:4]!=0, and SHALL ignore writes to those addresses.
REQ-020 SHALL return bits[31:16] as 0 on LED reads, and bits[31:3] as 0 on TIMER_CTRL reads.
REQ-021 SHALL increment TIMER_CNT by 1 per cycle while EN=1; the increment wraps from 32'hFFFF_FFFF to 0.
REQ-022 SHALL, in a cycle with EN=1 and TIMER_CNT==TIMER_CMP, set PEND; TIMER_CNT then becomes 0 if AUTO=1; if AUTO=0, EN clears and TIMER_CNT holds.
REQ-023 SHALL handle a TIMER_CTRL write as follows: EN and AUTO take din[0] and din[2]; din[1]=1 clears PEND; a 0->1 transition of EN clears TIMER_CNT to 0.
REQ-024 SHALL resolve a compare hit and a software PEND clear in the same cycle by leaving PEND=1 (set wins).
REQ-025 SHALL resolve a compare hit and a TIMER_CTRL write in the same cycle by letting the written EN/AUTO override the hardware EN update.
REQ-026 SHALL drive int_o[0]=PEND and int_o[5:1]=0, from registers with no combinational path from inputs.
REQ-027 SHALL return the pre-update TIMER_CNT value on a TIMER_CNT read, i.e. the value in the read cycle.

Reset
REQ-028 SHALL, while rst=1, immediately force dm=0, led=0, int_o=0, TIMER_CNT=0, TIMER_CMP=CMP_RESET, and EN=PEND=AUTO=0.
REQ-029 SHALL NOT reset RAM contents.
REQ-030 SHALL abort any in-flight read when rst asserts mid-access; dm reads 0 after reset is released.

Configuration
REQ-031 SHALL, when macro DMEM_TIMER_EN is defined, implement the timer per REQ-021..REQ-027.
REQ-032 SHALL, when DMEM_TIMER_EN is undefined, omit the timer registers: offsets 1..3 read 0, their writes are ignored, and int_o is constant 0.

Verification
REQ-033 SHALL cover: write 0x1122_3344 to 0x0000_0010 with we=1111, then with we=0100 write din=0x00AB_0000, then read -> dm=0x11AB_3344 one cycle after the read.
REQ-034 SHALL cover: write 0xDEAD_BEEF to 0x0000_1010 (DEPTH_LOG2=10), then read 0x0000_0010 -> dm=0xDEAD_BEEF (alias).
REQ-035 SHALL cover: write LED=0xFFFF_A5A5 -> led=0xA5A5 and LED read=0x0000_A5A5; a we=0011 write of 0 -> led unchanged.
REQ-036 SHALL cover: CMP=5, CTRL=0x5 -> int_o[0] rises exactly 6 cycles after the CTRL write edge and TIMER_CNT restarts at 0; CTRL write 0x7 on the next hit cycle -> PEND stays 1.
REQ-037 SHALL cover: CMP=3, CTRL=0x1 (AUTO=0) -> after the hit EN=0, TIMER_CNT holds 3, and CTRL reads 0x2.
REQ-038 SHALL cover: assert rst mid-read while timer is running -> dm, int_o, and led are 0 in the same cycle, asynchronously, and TIMER_CMP reads CMP_RESET after release.

Source files
------------

// File: rtl/dmem_bridge.sv
// Data-memory bridge: byte-lane RAM plus an MMIO block (LED, and the timer when DMEM_TIMER_EN is defined).
// Reads return one cycle after the access; there is no backpressure, so an access completes in the cycle it is presented.
module dmem_bridge #(
   parameter int          DEPTH_LOG2 = 10,
   parameter logic [31:0] CMP_RESET  = 32'hFFFF_FFFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        dce,
   input  logic [31:0] daddr,
   input  logic [3:0]  we,
   input  logic [31:0] din,
   output logic [31:0] dm,
   output logic [5:0]  int_o,
   output logic [15:0] led
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [31:0]           mem [DEPTH];
   logic [DEPTH_LOG2-1:0] widx;
   logic                  is_mmio;
   logic                  mmio_hit;
   logic                  rd_en;
   logic                  wr_en;
   logic                  ram_wr;
   logic                  mmio_wr;
   logic [1:0]            reg_sel;
   logic [31:0]           rd_data;
   logic                  addr_unused;

   assign widx        = daddr[DEPTH_LOG2+1:2];
   assign reg_sel     = daddr[3:2];
   assign is_mmio     = (daddr[31:28] == 4'hA);
   assign mmio_hit    = is_mmio && (daddr[27:4] == 24'h0);
   assign rd_en       = dce && (we == 4'b0000);
   assign wr_en       = dce && (we != 4'b0000);
   assign ram_wr      = wr_en && !is_mmio;
   assign mmio_wr     = wr_en && mmio_hit && (we == 4'b1111);
   assign addr_unused = ^daddr[1:0];

   // RAM contents survive reset on purpose.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (ram_wr && we[i]) begin
            mem[widx][8*i +: 8] <= din[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         led <= 16'h0;
      end else if (mmio_wr && (reg_sel == 2'd0)) begin
         led <= din[15:0];
      end
   end

`ifdef DMEM_TIMER_EN
   logic [31:0] cnt_q, cnt_d;
   logic [31:0] cmp_q, cmp_d;
   logic        en_q, en_d;
   logic        pend_q, pend_d;
   logic        auto_q, auto_d;
   logic        hit;
   logic        ctrl_wr;
   logic        cmp_wr;

   assign hit     = en_q && (cnt_q == cmp_q);
   assign ctrl_wr = mmio_wr && (reg_sel == 2'd3);
   assign cmp_wr  = mmio_wr && (reg_sel == 2'd2);

   always_comb begin
      cnt_d  = cnt_q;
      cmp_d  = cmp_q;
      en_d   = en_q;
      pend_d = pend_q;
      auto_d = auto_q;
      if (en_q) begin
         cnt_d = cnt_q + 32'd1;
      end
      if (hit) begin
         pend_d = 1'b1;
         if (auto_q) begin
            cnt_d = 32'h0;
         end else begin
            en_d  = 1'b0;
            cnt_d = cnt_q;
         end
      end
      if (cmp_wr) begin
         cmp_d = din;
      end
      // Software write overrides the hardware EN update, but a hit still sets PEND.
      if (ctrl_wr) begin
         en_d   = din[0];
         auto_d = din[2];
         if (din[1] && !hit) begin
            pend_d = 1'b0;
         end
         if (din[0] && !en_q) begin
            cnt_d = 32'h0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= 32'h0;
         cmp_q  <= CMP_RESET;
         en_q   <= 1'b0;
         pend_q <= 1'b0;
         auto_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         cmp_q  <= cmp_d;
         en_q   <= en_d;
         pend_q <= pend_d;
         auto_q <= auto_d;
      end
   end

   assign int_o = {5'b0, pend_q};
`else
   assign int_o = 6'b0;
`endif

   always_comb begin
      rd_data = 32'h0;
      if (!is_mmio) begin
         rd_data = mem[widx];
      end else if (mmio_hit) begin
         case (reg_sel)
            2'd0:    rd_data = {16'h0, led};
`ifdef DMEM_TIMER_EN
            2'd1:    rd_data = cnt_q;
            2'd2:    rd_data = cmp_q;
            2'd3:    rd_data = {29'h0, auto_q, pend_q, en_q};
`endif
            default: rd_data = 32'h0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dm <= 32'h0;
      end else if (rd_en) begin
         dm <= rd_data;
      end
   end

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed self-checking bench for dmem_bridge; timer scenarios follow DMEM_TIMER_EN.
module tb_dmem_bridge;

   logic        clk;
   logic        rst;
   logic        dce;
   logic [31:0] daddr;
   logic [3:0]  we;
   logic [31:0] din;
   logic [31:0] dm;
   logic [5:0]  int_o;
   logic [15:0] led;

   int n_cmp = 0;
   int n_bad = 0;

`ifdef DMEM_TIMER_EN
   localparam logic [31:0] EXP_CMP = 32'hFFFF_FFFF;
`else
   localparam logic [31:0] EXP_CMP = 32'h0;
`endif

   dmem_bridge #(.DEPTH_LOG2(10), .CMP_RESET(32'hFFFF_FFFF)) dut (
      .clk   (clk),
      .rst   (rst),
      .dce   (dce),
      .daddr (daddr),
      .we    (we),
      .din   (din),
      .dm    (dm),
      .int_o (int_o),
      .led   (led)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
      daddr = a;
      din   = d;
      we    = w;
      dce   = 1'b1;
      tick();
      dce   = 1'b0;
      we    = 4'b0000;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      daddr = a;
      we    = 4'b0000;
      dce   = 1'b1;
      tick();
      d     = dm;
      dce   = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] r;
      rst = 1'b1;
      dce = 1'b0; daddr = 32'h0; we = 4'b0000; din = 32'h0;
      tick(); tick();
      n_cmp++; if (dm !== 32'h0) begin n_bad++; $display("FAIL reset_dm got %h want %h", dm, 32'h0); end
      n_cmp++; if (led !== 16'h0) begin n_bad++; $display("FAIL reset_led got %h want %h", led, 16'h0); end
      n_cmp++; if (int_o !== 6'h0) begin n_bad++; $display("FAIL reset_int got %h want %h", int_o, 6'h0); end
      rst = 1'b0;
      tick();
      rd(32'hA000_0008, r);
      n_cmp++; if (r !== EXP_CMP) begin n_bad++; $display("FAIL reset_cmp got %h want %h", r, EXP_CMP); end
   endtask

   task automatic test_byte_lanes();
      logic [31:0] r;
      wr(32'h0000_0010, 32'h1122_3344, 4'b1111);
      wr(32'h0000_0010, 32'h00AB_0000, 4'b0100);
      rd(32'h0000_0010, r);
      n_cmp++; if (r !== 32'h11AB_3344) begin n_bad++; $display("FAIL byte_lane got %h want %h", r, 32'h11AB_3344); end
      tick();
      n_cmp++; if (dm !== 32'h11AB_3344) begin n_bad++; $display("FAIL hold_idle got %h want %h", dm, 32'h11AB_3344); end
      wr(32'h0000_0020, 32'h5555_6666, 4'b1111);
      n_cmp++; if (dm !== 32'h11AB_3344) begin n_bad++; $display("FAIL hold_write got %h want %h", dm, 32'h11AB_3344); end
   endtask

   task automatic test_alias();
      logic [31:0] r;
      wr(32'h0000_1010, 32'hDEAD_BEEF, 4'b1111);
      rd(32'h0000_0010, r);
      n_cmp++; if (r !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL alias got %h want %h", r, 32'hDEAD_BEEF); end
   endtask

   task automatic test_back_to_back();
      wr(32'h0000_0024, 32'h0BAD_F00D, 4'b1111);
      dce = 1'b1; we = 4'b0000;
      daddr = 32'h0000_0020;
      tick();
      n_cmp++; if (dm !== 32'h5555_6666) begin n_bad++; $display("FAIL b2b_first got %h want %h", dm, 32'h5555_6666); end
      daddr = 32'h0000_0024;
      tick();
      n_cmp++; if (dm !== 32'h0BAD_F00D) begin n_bad++; $display("FAIL b2b_second got %h want %h", dm, 32'h0BAD_F00D); end
      dce = 1'b0;
   endtask

   task automatic test_led();
      logic [31:0] r;
      wr(32'hA000_0000, 32'hFFFF_A5A5, 4'b1111);
      n_cmp++; if (led !== 16'hA5A5) begin n_bad++; $display("FAIL led_write got %h want %h", led, 16'hA5A5); end
      rd(32'hA000_0000, r);
      n_cmp++; if (r !== 32'h0000_A5A5) begin n_bad++; $display("FAIL led_read got %h want %h", r, 32'h0000_A5A5); end
      wr(32'hA000_0000, 32'h0, 4'b0011);
      n_cmp++; if (led !== 16'hA5A5) begin n_bad++; $display("FAIL led_partial got %h want %h", led, 16'hA5A5); end
      wr(32'hA000_0010, 32'h0, 4'b1111);
      n_cmp++; if (led !== 16'hA5A5) begin n_bad++; $display("FAIL led_hole_wr got %h want %h", led, 16'hA5A5); end
      rd(32'hA000_0010, r);
      n_cmp++; if (r !== 32'h0) begin n_bad++; $display("FAIL hole_read got %h want %h", r, 32'h0); end
   endtask

`ifdef DMEM_TIMER_EN
   task automatic test_timer_auto();
      logic [31:0] r;
      wr(32'hA000_0008, 32'd5, 4'b1111);
      wr(32'hA000_000C, 32'h5, 4'b1111);
      tick(); tick();
      rd(32'hA000_0004, r);
      n_cmp++; if (r !== 32'd2) begin n_bad++; $display("FAIL cnt_run got %h want %h", r, 32'd2); end
      tick(); tick();
      n_cmp++; if (int_o !== 6'h00) begin n_bad++; $display("FAIL int_early got %h want %h", int_o, 6'h00); end
      tick();
      n_cmp++; if (int_o !== 6'h01) begin n_bad++; $display("FAIL int_edge6 got %h want %h", int_o, 6'h01); end
      rd(32'hA000_0004, r);
      n_cmp++; if (r !== 32'd0) begin n_bad++; $display("FAIL cnt_restart got %h want %h", r, 32'd0); end
      repeat (4) tick();
      wr(32'hA000_000C, 32'h7, 4'b1111);
      n_cmp++; if (int_o !== 6'h01) begin n_bad++; $display("FAIL pend_set_wins got %h want %h", int_o, 6'h01); end
      wr(32'hA000_000C, 32'h7, 4'b1111);
      n_cmp++; if (int_o !== 6'h00) begin n_bad++; $display("FAIL pend_clear got %h want %h", int_o, 6'h00); end
      wr(32'hA000_000C, 32'h2, 4'b1111);
   endtask

   task automatic test_timer_oneshot();
      logic [31:0] r;
      wr(32'hA000_0008, 32'd3, 4'b1111);
      wr(32'hA000_000C, 32'h1, 4'b1111);
      repeat (4) tick();
      n_cmp++; if (int_o !== 6'h01) begin n_bad++; $display("FAIL oneshot_int got %h want %h", int_o, 6'h01); end
      rd(32'hA000_0004, r);
      n_cmp++; if (r !== 32'd3) begin n_bad++; $display("FAIL oneshot_cnt got %h want %h", r, 32'd3); end
      rd(32'hA000_000C, r);
      n_cmp++; if (r !== 32'h2) begin n_bad++; $display("FAIL oneshot_ctrl got %h want %h", r, 32'h2); end
      repeat (3) tick();
      rd(32'hA000_0004, r);
      n_cmp++; if (r !== 32'd3) begin n_bad++; $display("FAIL oneshot_hold got %h want %h", r, 32'd3); end
      wr(32'hA000_000C, 32'h2, 4'b1111);
   endtask
`else
   task automatic test_no_timer();
      logic [31:0] r;
      wr(32'hA000_0008, 32'd5, 4'b1111);
      rd(32'hA000_0008, r);
      n_cmp++; if (r !== 32'h0) begin n_bad++; $display("FAIL notimer_cmp got %h want %h", r, 32'h0); end
      wr(32'hA000_000C, 32'h5, 4'b1111);
      repeat (8) tick();
      n_cmp++; if (int_o !== 6'h0) begin n_bad++; $display("FAIL notimer_int got %h want %h", int_o, 6'h0); end
      rd(32'hA000_000C, r);
      n_cmp++; if (r !== 32'h0) begin n_bad++; $display("FAIL notimer_ctrl got %h want %h", r, 32'h0); end
      rd(32'hA000_0004, r);
      n_cmp++; if (r !== 32'h0) begin n_bad++; $display("FAIL notimer_cnt got %h want %h", r, 32'h0); end
   endtask
`endif

   task automatic test_reset_mid_read();
      logic [31:0] r;
`ifdef DMEM_TIMER_EN
      wr(32'hA000_0008, 32'd2, 4'b1111);
      wr(32'hA000_000C, 32'h5, 4'b1111);
      repeat (3) tick();
      n_cmp++; if (int_o !== 6'h01) begin n_bad++; $display("FAIL pre_rst_int got %h want %h", int_o, 6'h01); end
`endif
      rd(32'h0000_0010, r);
      n_cmp++; if (r !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL pre_rst_dm got %h want %h", r, 32'hDEAD_BEEF); end
      daddr = 32'h0000_0024;
      we    = 4'b0000;
      dce   = 1'b1;
      #2 rst = 1'b1;
      #1;
      n_cmp++; if (dm !== 32'h0) begin n_bad++; $display("FAIL async_rst_dm got %h want %h", dm, 32'h0); end
      n_cmp++; if (int_o !== 6'h0) begin n_bad++; $display("FAIL async_rst_int got %h want %h", int_o, 6'h0); end
      n_cmp++; if (led !== 16'h0) begin n_bad++; $display("FAIL async_rst_led got %h want %h", led, 16'h0); end
      tick();
      dce = 1'b0;
      rst = 1'b0;
      tick();
      n_cmp++; if (dm !== 32'h0) begin n_bad++; $display("FAIL post_rst_dm got %h want %h", dm, 32'h0); end
      n_cmp++; if (int_o !== 6'h0) begin n_bad++; $display("FAIL post_rst_int got %h want %h", int_o, 6'h0); end
      rd(32'hA000_0008, r);
      n_cmp++; if (r !== EXP_CMP) begin n_bad++; $display("FAIL post_rst_cmp got %h want %h", r, EXP_CMP); end
   endtask

   initial begin
      test_reset();
      test_byte_lanes();
      test_alias();
      test_back_to_back();
      test_led();
`ifdef DMEM_TIMER_EN
      test_timer_auto();
      test_timer_oneshot();
`else
      test_no_timer();
`endif
      test_reset_mid_read();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
